note_arpeggiator: RTL

NOTE_ARPEGGIATOR -- requirements
Module: note_arpeggiator

---
 rtl/note_arpeggiator.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/note_arpeggiator.sv
// Key debouncer and arpeggiator: turns held keys into a stepped, gated note sequence
// (or passes them straight through in mode 00) for the synth's active-low note enables.
module note_arpeggiator #(
  parameter int NNOTES    = 5,
  parameter int DEB_LEN   = 1024,
  parameter int TICK_UNIT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NNOTES-1:0] keys_n,
  input  logic [3:0]        tempo,
  input  logic [1:0]        mode,
  output logic [NNOTES-1:0] note_enn,
  output logic              step_strobe,
  output logic [2:0]        cur_note,
  output logic              active
);

  localparam int DW = $clog2(DEB_LEN + 1);
  localparam int PW = $clog2(16 * TICK_UNIT + 1);

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_UPDOWN = 2'b11;

  typedef enum logic [1:0] {IDLE, GATE_ON, GATE_OFF} state_t;

  logic [NNOTES-1:0] sync1, sync2, stable_n, held;
  logic [DW-1:0]     deb_cnt [NNOTES];
  logic [3:0]        tempo_q;
  logic [PW-1:0]     phase, period;
  logic              tick, gate_end;
  state_t            state;
  logic              dir_up;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= keys_n;
      sync2 <= sync1;
    end
  end

  // A bit flips only after DEB_LEN consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_n <= '1;
      // NOTE: the counter array is tiny and its start value matters, so each
      // element is reset explicitly rather than left to power-up state.
      for (int i = 0; i < NNOTES; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NNOTES; i++) begin
        if (sync2[i] == stable_n[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_LEN - 1)) begin
          stable_n[i] <= sync2[i];
          deb_cnt[i]  <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign held     = ~stable_n;
  assign period   = PW'((32'd16 - 32'(tempo_q)) * 32'(TICK_UNIT));
  assign tick     = (phase == period - PW'(1));
  assign gate_end = (phase == (period >> 1) - PW'(1));

  // tempo_q starts at 0, so the first step period after reset is the slowest one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      tempo_q <= '0;
    end else if (tick) begin
      phase   <= '0;
      tempo_q <= tempo;
    end else begin
      phase <= phase + PW'(1);
    end
  end

  logic              found_up, found_dn, next_dir;
  logic [2:0]        idx_up, idx_dn, idx_lo, idx_hi, first_note, next_note;
  logic [NNOTES-1:0] gate_pattern;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    found_up = 1'b0;
    found_dn = 1'b0;
    idx_up   = '0;
    idx_dn   = '0;
    idx_lo   = '0;
    idx_hi   = '0;
    // Descending scans leave the lowest match, ascending scans the highest.
    for (int i = NNOTES - 1; i >= 0; i--) begin
      if (held[i]) idx_lo = 3'(i);
      if (held[i] && 3'(i) > cur_note) begin
        found_up = 1'b1;
        idx_up   = 3'(i);
      end
    end
    for (int i = 0; i < NNOTES; i++) begin
      if (held[i]) idx_hi = 3'(i);
      if (held[i] && 3'(i) < cur_note) begin
        found_dn = 1'b1;
        idx_dn   = 3'(i);
      end
    end

    first_note = (mode == MODE_DOWN) ? idx_hi : idx_lo;
    next_note  = cur_note;
    next_dir   = dir_up;
    case (mode)
      MODE_UP:   next_note = found_up ? idx_up : idx_lo;
      MODE_DOWN: next_note = found_dn ? idx_dn : idx_hi;
      MODE_UPDOWN: begin
        if (dir_up && found_up) begin
          next_note = idx_up;
        end else if (!dir_up && found_dn) begin
          next_note = idx_dn;
        end else begin
          next_dir = !dir_up;
          if (dir_up) next_note = found_dn ? idx_dn : idx_lo;
          else        next_note = found_up ? idx_up : idx_lo;
        end
      end
      default: next_note = cur_note;
    endcase

    gate_pattern = '1;
    for (int i = 0; i < NNOTES; i++) begin
      if (state == GATE_ON && 3'(i) == cur_note && held[i]) gate_pattern[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_note    <= '0;
      dir_up      <= 1'b1;
      step_strobe <= 1'b0;
      note_enn    <= '1;
      active      <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      active      <= |held;
      note_enn    <= (mode == MODE_PASS) ? stable_n : gate_pattern;
      if (held == '0 || mode == MODE_PASS) begin
        if (state != IDLE) begin
          state    <= IDLE;
          cur_note <= '0;
          dir_up   <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (tick) begin
              state       <= GATE_ON;
              cur_note    <= first_note;
              dir_up      <= 1'b1;
              step_strobe <= 1'b1;
            end
          end
          GATE_ON, GATE_OFF: begin
            if (tick) begin
              state       <= GATE_ON;
              cur_note    <= next_note;
              dir_up      <= next_dir;
              step_strobe <= 1'b1;
            end else if (state == GATE_ON && gate_end) begin
              state <= GATE_OFF;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
